// File: rtl/l2_arb_pkg.sv
`default_nettype none
// l2_arb_pkg: state, op and port-index definitions shared by the L2 port arbiter files.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  // A request with both read and write raised is treated as a read.
  function automatic arb_op_t decode_op(input logic rd);
    return rd ? OP_READ : OP_WRITE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_arb_pick.sv
`default_nettype none
// l2_arb_pick: combinational 2-way grant select.
// L2_ARB_RR_EN selects round-robin on a tie; otherwise port 0 always wins a tie.
module l2_arb_pick
  import l2_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       port
);

  assign valid = |req;

`ifdef L2_ARB_RR_EN
  always_comb begin
    port = PORT_D;
    if (req == 2'b11) begin
      port = ~last;
    end else if (req[PORT_I]) begin
      port = PORT_I;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    port = PORT_D;
    if (!req[PORT_D] && req[PORT_I]) begin
      port = PORT_I;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/l2_port_arbiter.sv
`default_nettype none
// l2_port_arbiter: grants one of two L1 requesters, sequences a single L2 access with a watchdog,
// and returns the response to the granted port. L2_ARB_RR_EN enables round-robin tie breaking.
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int BLOCK_SIZE     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            req0_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] req0_data_in,
  input  logic                             req0_read,
  input  logic                             req0_write,
  output logic                             req0_ready,
  output logic                             req0_hit,
  output logic                             req0_block_valid,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] req0_data_out,
  input  logic [ADDR_WIDTH-1:0]            req1_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] req1_data_in,
  input  logic                             req1_read,
  input  logic                             req1_write,
  output logic                             req1_ready,
  output logic                             req1_hit,
  output logic                             req1_block_valid,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] req1_data_out,
  output logic [ADDR_WIDTH-1:0]            l2_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_out,
  output logic                             l2_read,
  output logic                             l2_write,
  input  logic                             l2_ready,
  input  logic                             l2_hit,
  input  logic                             l2_block_valid,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_in,
  output logic                             timeout
);

  localparam int BW = BLOCK_SIZE * DATA_WIDTH;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_t      state;
  arb_state_t      state_nxt;
  arb_op_t         op;
  logic            gnt;
  logic            last_gnt;
  logic            pick_valid;
  logic            pick_port;
  logic            timed_out;
  logic            wd_expire;
  logic [1:0]      req_vec;
  logic [CW-1:0]   wd_cnt;
  logic [1:0]      hit_r;
  logic [1:0]      bv_r;
  logic [BW-1:0]   data_r [2];

  assign req_vec = {req1_read | req1_write, req0_read | req0_write};

  l2_arb_pick u_pick (
    .req   (req_vec),
    .last  (last_gnt),
    .valid (pick_valid),
    .port  (pick_port)
  );

  // The last WAIT cycle aborts only if the L2 has not answered in that same cycle.
  assign wd_expire = (state == WAIT) && !l2_ready && (wd_cnt == WD_LAST);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (l2_ready || wd_expire) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt         <= PORT_D;
      op          <= OP_READ;
      l2_addr     <= '0;
      l2_data_out <= '0;
      wd_cnt      <= '0;
      timed_out   <= 1'b0;
      hit_r       <= '0;
      bv_r        <= '0;
      data_r[0]   <= '0;
      data_r[1]   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt <= pick_port;
            if (pick_port == PORT_I) begin
              l2_addr     <= req1_addr;
              l2_data_out <= req1_data_in;
              op          <= decode_op(req1_read);
            end else begin
              l2_addr     <= req0_addr;
              l2_data_out <= req0_data_in;
              op          <= decode_op(req0_read);
            end
          end
        end
        ISSUE: begin
          wd_cnt    <= '0;
          timed_out <= 1'b0;
        end
        WAIT: begin
          if (l2_ready) begin
            hit_r[gnt]  <= l2_hit;
            bv_r[gnt]   <= l2_block_valid;
            data_r[gnt] <= l2_data_in;
          end else if (wd_expire) begin
            // Abort keeps the previously returned block on the port.
            hit_r[gnt] <= 1'b0;
            bv_r[gnt]  <= 1'b0;
            timed_out  <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef L2_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= PORT_I;
    end else if ((state == IDLE) && pick_valid) begin
      last_gnt <= pick_port;
    end
  end
`else
  assign last_gnt = PORT_I;
`endif

  assign l2_read          = (state == ISSUE) && (op == OP_READ);
  assign l2_write         = (state == ISSUE) && (op == OP_WRITE);
  assign timeout          = (state == RESP) && timed_out;

  assign req0_ready       = (state == RESP) && (gnt == PORT_D);
  assign req0_hit         = hit_r[PORT_D];
  assign req0_block_valid = bv_r[PORT_D];
  assign req0_data_out    = data_r[PORT_D];

  assign req1_ready       = (state == RESP) && (gnt == PORT_I);
  assign req1_hit         = hit_r[PORT_I];
  assign req1_block_valid = bv_r[PORT_I];
  assign req1_data_out    = data_r[PORT_I];

endmodule
`default_nettype wire
